fft_bitrev_reorder: RTL

- Sits directly downstream of the 1024-point R2²SDF FFT core and consumes its output stream.
- The core emits each frame's bins in bit-reversed order. This block writes each frame into a ping-pong buffer at bit-reversed addresses, then streams it out in natural order (bin 0..N-1).
- Output carries the same enable/real/imag convention, plus the bin index.

---
 rtl/fft_bitrev_reorder_pkg.sv | 41 ++++
 rtl/fft_bitrev_reorder_ram.sv | 54 +++++
 rtl/fft_bitrev_reorder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// ----------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared definitions for the FFT bit-reversal reorder buffer:
//   - read FSM state encodings (IDLE / READ)
//   - clog2   : constant function used to confirm LOG_N matches N
//   - bitrev  : reverses the low 'bits' bits of a value (FFT bin addressing)
// No ports; imported by the top level and the RAM.
// ----------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

   // Read FSM encodings, kept as plain constants so older tools can use them.
   localparam logic IDLE = 1'b0;
   localparam logic READ = 1'b1;

   // Smallest r with 2**r >= value.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < value) begin
            result = b + 1;
         end
      end
      return result;
   endfunction

   // Reverse the low 'bits' bits of value; higher bits are dropped.
   // Built by shifting bits into the result LSB-first, which avoids any
   // variable-position writes into the result vector.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
      logic [31:0] result;
      result = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < bits) begin
            result = {result[30:0], value[b]};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// ----------------------------------------------------------------------------
// reorder_ram
// Simple dual-port RAM holding both ping-pong banks of the reorder buffer.
//   clock     : single clock for both ports
//   reset     : synchronous, clears only the read data register
//   we_i      : write enable
//   waddr_i   : write address {bank, bin}
//   wdata_i   : write data {real, imag}
//   re_i      : read enable; read data register holds when low
//   raddr_i   : read address {bank, bin}
//   rdata_o   : registered read data, valid one cycle after re_i
// Array contents are never cleared.
// ----------------------------------------------------------------------------
module reorder_ram
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Storage array: written on the write port only, deliberately without
   // reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Read data register. It holds while re_i is low so the block output
   // keeps its last sample between frames, and resets so an aborted output
   // frame leaves zeros behind.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ----------------------------------------------------------------------------
// fft_bitrev_reorder
// Converts the bit-reversed bin stream of the FFT core into natural order.
// Each input frame is written into one half of a ping-pong RAM at bit-reversed
// addresses; once complete it is streamed out as bins 0..N-1 at one sample
// per cycle while the next frame fills the other half.
//   clock      : master clock
//   reset      : synchronous active-high reset
//   idata_en   : input sample valid (gaps allowed)
//   idata_r/i  : input real/imag, bit-reversed bin order
//   odata_en   : output sample valid
//   odata_r/i  : output real/imag, natural bin order
//   odata_idx  : bin index of the current output sample
// Latency: last input accepted in cycle T gives odata_en in cycles T+2..T+N+1.
// ----------------------------------------------------------------------------
module fft_bitrev_reorder
   import fft_bitrev_reorder_pkg::*;
#(
   parameter int N     = 1024,
   parameter int LOG_N = 10,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             idata_en,
   input  logic [WIDTH-1:0] idata_r,
   input  logic [WIDTH-1:0] idata_i,
   output logic             odata_en,
   output logic [WIDTH-1:0] odata_r,
   output logic [WIDTH-1:0] odata_i,
   output logic [LOG_N-1:0] odata_idx
);

   // Reject inconsistent parameter sets at elaboration.
   if (N < 4 || LOG_N != clog2(N) || (1 << LOG_N) != N) begin : g_paramCheck
      $error("fft_bitrev_reorder: N must be a power of 2 >= 4 and LOG_N = log2(N)");
   end

   localparam logic [LOG_N-1:0] LastBin = LOG_N'(N - 1);

   logic [LOG_N-1:0]   wCnt_q, wCnt_d;
   logic               wBank_q, wBank_d;
   logic               rState_q, rState_d;
   logic [LOG_N-1:0]   rCnt_q, rCnt_d;
   logic               rBank_q, rBank_d;
   logic               odataEn_q;
   logic [LOG_N-1:0]   odataIdx_q;

   logic               frameDone;
   logic               ramWe;
   logic [LOG_N:0]     ramWAddr;
   logic [LOG_N:0]     ramRAddr;
   logic               ramRe;
   logic [2*WIDTH-1:0] ramRData;

   // A frame completes when its last bin is accepted; this doubles as the
   // start pulse for the reader, which takes the bank just finished.
   assign frameDone = idata_en && (wCnt_q == LastBin);

   assign ramWe    = idata_en && !reset;
   assign ramWAddr = {wBank_q, LOG_N'(bitrev(32'(wCnt_q), LOG_N))};
   assign ramRe    = (rState_q == READ);
   assign ramRAddr = {rBank_q, rCnt_q};

   // Write counter and bank select. Idle input cycles simply stall the
   // counter, so gaps never split a frame.
   always_comb begin
      wCnt_d  = wCnt_q;
      wBank_d = wBank_q;
      if (idata_en) begin
         if (frameDone) begin
            wCnt_d  = '0;
            wBank_d = !wBank_q;
         end else begin
            wCnt_d = wCnt_q + 1'b1;
         end
      end
   end

   // Read FSM. A start arriving on the last read address restarts the
   // sequence immediately so back-to-back frames leave no bubble. The
   // writer needs N cycles per bank, so start cannot land mid-read.
   always_comb begin
      rState_d = rState_q;
      rCnt_d   = rCnt_q;
      rBank_d  = rBank_q;
      if (rState_q == IDLE) begin
         if (frameDone) begin
            rState_d = READ;
            rCnt_d   = '0;
            rBank_d  = wBank_q;
         end
      end else begin
         if (rCnt_q == LastBin) begin
            rCnt_d = '0;
            if (frameDone) begin
               rState_d = READ;
               rBank_d  = wBank_q;
            end else begin
               rState_d = IDLE;
            end
         end else begin
            rCnt_d = rCnt_q + 1'b1;
         end
      end
   end

   // State registers for both sides.
   always_ff @(posedge clock) begin
      if (reset) begin
         wCnt_q   <= '0;
         wBank_q  <= 1'b0;
         rState_q <= IDLE;
         rCnt_q   <= '0;
         rBank_q  <= 1'b0;
      end else begin
         wCnt_q   <= wCnt_d;
         wBank_q  <= wBank_d;
         rState_q <= rState_d;
         rCnt_q   <= rCnt_d;
         rBank_q  <= rBank_d;
      end
   end

   // Output valid and bin index track the RAM's one-cycle read latency;
   // the index holds between frames like the data does.
   always_ff @(posedge clock) begin
      if (reset) begin
         odataEn_q  <= 1'b0;
         odataIdx_q <= '0;
      end else begin
         odataEn_q <= ramRe;
         if (ramRe) begin
            odataIdx_q <= rCnt_q;
         end
      end
   end

   reorder_ram #(
      .ADDR_W (LOG_N + 1),
      .DATA_W (2 * WIDTH)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .we_i    (ramWe),
      .waddr_i (ramWAddr),
      .wdata_i ({idata_r, idata_i}),
      .re_i    (ramRe),
      .raddr_i (ramRAddr),
      .rdata_o (ramRData)
   );

   assign odata_en  = odataEn_q;
   assign odata_r   = ramRData[2*WIDTH-1:WIDTH];
   assign odata_i   = ramRData[WIDTH-1:0];
   assign odata_idx = odataIdx_q;

endmodule
